// File: rtl/qed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qed_pkg
// Description : Shared opcode constants, scheduler state encoding and the
//               duplicate-eligibility function. Honours QED_STORE_DUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package qed_pkg;

    localparam logic [6:0] c_OPC_R     = 7'b0110011;
    localparam logic [6:0] c_OPC_I     = 7'b0010011;
    localparam logic [6:0] c_OPC_LW    = 7'b0000011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;

    typedef enum logic [0:0] {
        ST_ORIG = 1'b0,
        ST_DUP  = 1'b1
    } qed_state_t;

    // Anything not listed here is a barrier and forces a buffer drain first.
    function automatic logic qed_is_eligible(input logic [31:0] instr);
        logic r_elig;
        r_elig = 1'b0;
        case (instr[6:0])
            c_OPC_R, c_OPC_I, c_OPC_LW, c_OPC_LUI, c_OPC_AUIPC: r_elig = 1'b1;
`ifdef QED_STORE_DUP_EN
            c_OPC_STORE: r_elig = 1'b1;
`endif
            default: r_elig = 1'b0;
        endcase
        return r_elig;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qed_dup_fifo.sv
`default_nettype none
// ============================================================================
// Module      : qed_dup_fifo
// Description : Power-of-two FIFO holding original instructions awaiting
//               duplicate issue. Storage array carries no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module qed_dup_fifo
    import qed_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [31:0]                i_data,
    output logic [31:0]                o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [31:0]       r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qed_dup_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : qed_dup_scheduler
// Description : Issues fetched originals, buffers eligible ones and replays
//               them as duplicates before barriers. Macro: QED_STORE_DUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                ifu_qed_instruction,
    input  logic                       ifu_valid,
    output logic                       qed_ready,
    input  logic                       exec_dup,
    input  logic                       core_ready,
    output logic [31:0]                qed_instruction,
    output logic                       qed_valid,
    output logic                       qed_is_dup,
    output logic [$clog2(DEPTH):0]     qed_count
);

    localparam int c_CW = $clog2(DEPTH) + 1;

    qed_state_t        r_state;
    qed_state_t        w_state_nxt;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic              r_is_dup;
    logic [31:0]       w_instr_nxt;
    logic              w_valid_nxt;
    logic              w_is_dup_nxt;

    logic              w_load;
    logic              w_barrier;
    logic              w_go_dup;
    logic              w_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_fifo_data;
    logic [c_CW-1:0]   w_count;
    logic              w_full;
    logic              w_empty;

    qed_dup_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (ifu_qed_instruction),
        .o_data  (w_fifo_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_load    = !r_valid || core_ready;
    assign w_barrier = !qed_is_eligible(ifu_qed_instruction);
    assign w_go_dup  = (r_state == ST_ORIG) && !w_empty &&
                       (exec_dup || w_full || (ifu_valid && w_barrier));
    // A pending drain takes priority over accepting the fetch.
    assign w_ready   = !rst && (r_state == ST_ORIG) && w_load && !w_full &&
                       !(w_barrier && !w_empty) && !w_go_dup;
    assign w_accept  = ifu_valid && w_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_instr_nxt  = r_instr;
        w_valid_nxt  = r_valid;
        w_is_dup_nxt = r_is_dup;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_ORIG: begin
                if (w_go_dup) begin
                    w_state_nxt = ST_DUP;
                end
                w_push = w_accept && !w_barrier;
                if (w_load) begin
                    w_valid_nxt  = w_accept;
                    w_is_dup_nxt = 1'b0;
                    if (w_accept) begin
                        w_instr_nxt = ifu_qed_instruction;
                    end
                end
            end
            ST_DUP: begin
                if (w_load) begin
                    w_pop        = !w_empty;
                    w_valid_nxt  = !w_empty;
                    w_is_dup_nxt = !w_empty;
                    if (!w_empty) begin
                        w_instr_nxt = w_fifo_data;
                    end
                    if (w_count <= c_CW'(1)) begin
                        w_state_nxt = ST_ORIG;
                    end
                end
            end
            default: w_state_nxt = ST_ORIG;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ORIG;
            r_instr  <= 32'h0;
            r_valid  <= 1'b0;
            r_is_dup <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_instr  <= w_instr_nxt;
            r_valid  <= w_valid_nxt;
            r_is_dup <= w_is_dup_nxt;
        end
    end

    assign qed_ready       = w_ready;
    assign qed_instruction = r_instr;
    assign qed_valid       = r_valid;
    assign qed_is_dup      = r_is_dup;
    assign qed_count       = w_count;

endmodule
`default_nettype wire

// File: tb/tb_qed_dup_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_qed_dup_scheduler
// Description : Directed self-checking bench for qed_dup_scheduler (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qed_dup_scheduler;

    localparam int DEPTH = 4;

    localparam logic [31:0] c_ADDI = 32'h00500093;
    localparam logic [31:0] c_ADD  = 32'h002081b3;
    localparam logic [31:0] c_LW   = 32'h0000a103;
    localparam logic [31:0] c_LUI  = 32'h000012b7;
    localparam logic [31:0] c_BEQ  = 32'h00208463;
    localparam logic [31:0] c_SW   = 32'h00112023;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_qed_instruction;
    logic        ifu_valid;
    logic        qed_ready;
    logic        exec_dup;
    logic        core_ready;
    logic [31:0] qed_instruction;
    logic        qed_valid;
    logic        qed_is_dup;
    logic [2:0]  qed_count;

    int n_checks;
    int n_fails;

    logic [31:0] r_vec [5];

    qed_dup_scheduler #(
        .DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ifu_qed_instruction (ifu_qed_instruction),
        .ifu_valid           (ifu_valid),
        .qed_ready           (qed_ready),
        .exec_dup            (exec_dup),
        .core_ready          (core_ready),
        .qed_instruction     (qed_instruction),
        .qed_valid           (qed_valid),
        .qed_is_dup          (qed_is_dup),
        .qed_count           (qed_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic d,
                           input logic [31:0] ins, input int cnt);
        chk({tag, "_valid"}, {31'b0, qed_valid}, {31'b0, v});
        chk({tag, "_dup"},   {31'b0, qed_is_dup}, {31'b0, d});
        if (v) chk({tag, "_instr"}, qed_instruction, ins);
        chk({tag, "_count"}, {29'b0, qed_count}, cnt);
    endtask

    task automatic offer(input logic [31:0] ins);
        ifu_qed_instruction = ins;
        ifu_valid           = 1'b1;
    endtask

    initial begin
        n_checks            = 0;
        n_fails             = 0;
        rst                 = 1'b1;
        ifu_qed_instruction = 32'h0;
        ifu_valid           = 1'b1;
        exec_dup            = 1'b0;
        core_ready          = 1'b1;
        repeat (2) cyc();

        // Reset state
        chk("rst_ready", {31'b0, qed_ready}, 32'd0);
        chk_out("rst", 1'b0, 1'b0, 32'h0, 0);
        chk("rst_instr", qed_instruction, 32'h0);
        ifu_valid = 1'b0;
        rst       = 1'b0;
        cyc();

        // Single ADDI passes through with latency 1 and is buffered
        offer(c_ADDI);
        #1 chk("addi_ready", {31'b0, qed_ready}, 32'd1);
        cyc();
        ifu_valid = 1'b0;
        chk_out("addi", 1'b1, 1'b0, c_ADDI, 1);

        // Two more eligibles, then exec_dup drains three in order
        offer(c_ADD);
        cyc();
        chk_out("add", 1'b1, 1'b0, c_ADD, 2);
        offer(c_LW);
        cyc();
        chk_out("lw", 1'b1, 1'b0, c_LW, 3);
        offer(c_LUI);
        exec_dup = 1'b1;
        #1 chk("exec_ready", {31'b0, qed_ready}, 32'd0);
        cyc();
        exec_dup = 1'b0;
        chk_out("enter_dup", 1'b0, 1'b0, 32'h0, 3);
        r_vec[0] = c_ADDI; r_vec[1] = c_ADD; r_vec[2] = c_LW;
        for (int i = 0; i < 3; i++) begin
            chk("dup3_ready", {31'b0, qed_ready}, 32'd0);
            cyc();
            chk_out("dup3", 1'b1, 1'b1, r_vec[i], 2 - i);
        end
        // LUI was held off during the drain and goes through now
        chk("after_dup3_ready", {31'b0, qed_ready}, 32'd1);
        cyc();
        chk_out("lui", 1'b1, 1'b0, c_LUI, 1);

        // Fill to DEPTH; the extra instruction stalls until four duplicates issue
        r_vec[0] = c_ADDI; r_vec[1] = c_ADD; r_vec[2] = c_LW; r_vec[3] = c_ADDI;
        r_vec[4] = c_ADD;
        for (int i = 1; i < 4; i++) begin
            offer(r_vec[i]);
            cyc();
            chk_out("fill", 1'b1, 1'b0, r_vec[i], i + 1);
        end
        offer(r_vec[4]);
        #1 chk("full_ready", {31'b0, qed_ready}, 32'd0);
        cyc();
        chk_out("full_enter", 1'b0, 1'b0, 32'h0, 4);
        r_vec[0] = c_LUI;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_out("full_dup", 1'b1, 1'b1, r_vec[i], 3 - i);
        end
        chk("fifth_ready", {31'b0, qed_ready}, 32'd1);
        cyc();
        ifu_valid = 1'b0;
        chk_out("fifth", 1'b1, 1'b0, c_ADD, 1);

        // Barrier waits for the buffered duplicate
        offer(c_BEQ);
        #1 chk("beq_stall", {31'b0, qed_ready}, 32'd0);
        cyc();
        chk_out("beq_enter", 1'b0, 1'b0, 32'h0, 1);
        cyc();
        chk_out("beq_dup", 1'b1, 1'b1, c_ADD, 0);
        chk("beq_ready", {31'b0, qed_ready}, 32'd1);
        cyc();
        ifu_valid = 1'b0;
        chk_out("beq", 1'b1, 1'b0, c_BEQ, 0);

        // exec_dup with an empty buffer is ignored
        exec_dup = 1'b1;
        cyc();
        exec_dup = 1'b0;
        chk_out("exec_empty", 1'b0, 1'b0, 32'h0, 0);
        chk("exec_empty_ready", {31'b0, qed_ready}, 32'd1);

        // Backpressure during the drain
        offer(c_LUI);
        cyc();
        offer(c_LW);
        cyc();
        ifu_valid = 1'b0;
        chk_out("bp_fill", 1'b1, 1'b0, c_LW, 2);
        exec_dup = 1'b1;
        cyc();
        cyc();
        chk_out("bp_dup0", 1'b1, 1'b1, c_LUI, 1);
        core_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("bp_hold", 1'b1, 1'b1, c_LUI, 1);
        end
        core_ready = 1'b1;
        cyc();
        exec_dup = 1'b0;
        chk_out("bp_dup1", 1'b1, 1'b1, c_LW, 0);
        cyc();
        chk_out("bp_done", 1'b0, 1'b0, 32'h0, 0);

        // Reset while two entries are buffered in DUP
        offer(c_ADDI);
        cyc();
        offer(c_ADD);
        cyc();
        ifu_valid = 1'b0;
        exec_dup  = 1'b1;
        cyc();
        exec_dup = 1'b0;
        chk_out("pre_rst", 1'b0, 1'b0, 32'h0, 2);
        rst = 1'b1;
        #1;
        chk_out("mid_rst", 1'b0, 1'b0, 32'h0, 0);
        chk("mid_rst_ready", {31'b0, qed_ready}, 32'd0);
        cyc();
        rst = 1'b0;
        offer(c_SW);
        cyc();
        ifu_valid = 1'b0;
`ifdef QED_STORE_DUP_EN
        chk_out("sw", 1'b1, 1'b0, c_SW, 1);
`else
        chk_out("sw", 1'b1, 1'b0, c_SW, 0);
`endif
        cyc();
        chk_out("post_rst_idle", 1'b0, 1'b0, 32'h0, qed_pkg::qed_is_eligible(c_SW) ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
